integral_image_gen: RTL

//  Builds the integral (summed-area) image that the face-detection cores consume. Takes a raster

---
 rtl/fd_pkg.sv | 25 ++
 rtl/ii_colbuf.sv | 23 ++
 rtl/integral_image_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/fd_pkg.sv
// Shared face-detection constants and FSM encoding, used by the integral image
// producer, the filter cores and the mask overlay stage.
package fd_pkg;
    localparam int PIX_W  = 8;
    localparam int ACC_W  = 32;
    localparam int MAX_W  = 1024;
    localparam int DEPTH  = 100000;
    localparam int ADDR_W = 17;
    localparam int GEO_W  = 11;
    localparam int X_W    = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fd_state_e;

    // A tile must be non-empty, fit the column buffer and fit the core image memory.
    function automatic logic geometry_ok(input logic [GEO_W-1:0] w, input logic [GEO_W-1:0] h);
        logic [31:0] area;
        area = 32'(w) * 32'(h);
        return (w != '0) && (32'(w) <= 32'(MAX_W)) && (h != '0) && (area <= 32'(DEPTH));
    endfunction
endpackage

// File: rtl/ii_colbuf.sv
// Column-sum buffer: one integral value per tile column, one write port and
// one combinational read port.
module ii_colbuf
    import fd_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [X_W-1:0]   waddr,
    input  logic [ACC_W-1:0] wdata,
    input  logic [X_W-1:0]   raddr,
    output logic [ACC_W-1:0] rdata
);
    logic [ACC_W-1:0] mem [MAX_W];

    // NOTE: no reset on the array; row 0 never reads it, so contents need no clearing and it maps to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/integral_image_gen.sv
// Streams a raster tile in and emits one summed-area value per pixel, tagged
// with its linear image-memory address.
module integral_image_gen
    import fd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [GEO_W-1:0]  width,
    input  logic [GEO_W-1:0]  height,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              ii_valid,
    output logic [ADDR_W-1:0] ii_addr,
    output logic [ACC_W-1:0]  ii_data,
    input  logic              ii_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    fd_state_e         state_q, state_d;
    logic [GEO_W-1:0]  geo_w_q, geo_h_q;
    logic [X_W-1:0]    x_q;
    logic [GEO_W-1:0]  y_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ACC_W-1:0]  row_sum_q, row_sum_d, col_rd, ii_d;
    logic              accept, last_col, last_pix, start_ok, err_d;

    assign pix_ready = (state_q == RUN) && (!ii_valid || ii_ready);
    assign accept    = pix_valid && pix_ready;
    assign last_col  = GEO_W'(x_q) == (geo_w_q - GEO_W'(1));
    assign last_pix  = last_col && (y_q == (geo_h_q - GEO_W'(1)));
    assign start_ok  = start && (state_q == IDLE) && geometry_ok(width, height);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

    // Row 0 and column 0 bypass their predecessors, so stale buffer data never leaks in.
    assign row_sum_d = ((x_q == '0) ? '0 : row_sum_q) + ACC_W'(pix_data);
    assign ii_d      = ((y_q == '0) ? '0 : col_rd) + row_sum_d;

    ii_colbuf u_colbuf (
        .clk   (clk),
        .we    (accept),
        .waddr (x_q),
        .wdata (ii_d),
        .raddr (x_q),
        .rdata (col_rd)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) state_d = RUN;
                    else          err_d   = 1'b1;
                end
            end
            RUN:     if (accept && last_pix)   state_d = DRAIN;
            DRAIN:   if (ii_valid && ii_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            err       <= 1'b0;
            geo_w_q   <= '0;
            geo_h_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            row_sum_q <= '0;
            ii_valid  <= 1'b0;
            ii_addr   <= '0;
            ii_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            err     <= err_d;
            if (start_ok) begin
                geo_w_q   <= width;
                geo_h_q   <= height;
                x_q       <= '0;
                y_q       <= '0;
                addr_q    <= '0;
                row_sum_q <= '0;
            end else if (accept) begin
                row_sum_q <= row_sum_d;
                addr_q    <= addr_q + ADDR_W'(1);
                if (last_col) begin
                    x_q <= '0;
                    y_q <= y_q + GEO_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
            // A same-cycle handshake and accept reloads directly, keeping one pixel per cycle.
            if (accept) begin
                ii_valid <= 1'b1;
                ii_addr  <= addr_q;
                ii_data  <= ii_d;
            end else if (ii_ready) begin
                ii_valid <= 1'b0;
            end
        end
    end
endmodule
